// File: rtl/ex_stage_buf.sv
// EX-stage entry buffer: skid (SKID=1) or single register (SKID=0) holding
// IR/PC/BD/exception/payload; head drives out_*, out_exc resolves overflow.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   flush         exception/eret clear; leaves a bubble carrying in_pc
//   in_valid/in_ready, in_ir, in_pc, in_bd, in_exc, in_data : upstream entry
//   over          ALU overflow for the head entry
//   out_valid/out_ready, out_ir, out_pc, out_bd, out_data, out_exc : head
//   count         occupied entries 0..2
module ex_stage_buf #(
    parameter int NCH  = 6,
    parameter int SKID = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic [NCH*32-1:0] in_data,
    input  logic              over,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [NCH*32-1:0] out_data,
    output logic [4:0]        out_exc,
    output logic [1:0]        count
);
    localparam int DW = NCH * 32;

    // state encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ready_q;
    logic   push, pop;
    logic   load_in, load_skid, shift, drain;

    logic [31:0]   head_ir, head_pc, skid_ir, skid_pc;
    logic          head_bd, skid_bd;
    logic [4:0]    head_exc, skid_exc;
    logic [DW-1:0] head_data, skid_data;

    logic [5:0] op, fn;
    logic       is_load, is_store, is_arith;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // state register; in_ready for the skid variant is a flop of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) state_nxt = ONE;
                ONE: begin
                    if (push && !pop && SKID != 0) state_nxt = FULL;
                    else if (pop && !push)         state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // outputs derived from state
    always_comb begin
        out_valid = (state != EMPTY);
        count     = state;
        if (SKID != 0) in_ready = ready_q;
        else           in_ready = (state == EMPTY) || out_ready;
    end

    // head is refilled from in_* only when it is empty or leaving this cycle;
    // otherwise a push parks in the skid register
    assign load_in   = push && (state == EMPTY || pop);
    assign load_skid = push && !pop && (state == ONE);
    assign shift     = pop && (state == FULL);
    assign drain     = pop && !push && (state == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ir   <= '0;
            head_pc   <= '0;
            head_bd   <= 1'b0;
            head_exc  <= '0;
            head_data <= '0;
        end else if (flush) begin
            // bubble keeps the PC so EPC can be taken from it
            head_ir   <= '0;
            head_pc   <= in_pc;
            head_bd   <= 1'b0;
            head_exc  <= '0;
            head_data <= '0;
        end else if (load_in) begin
            head_ir   <= in_ir;
            head_pc   <= in_pc;
            head_bd   <= in_bd;
            head_exc  <= in_exc;
            head_data <= in_data;
        end else if (shift) begin
            head_ir   <= skid_ir;
            head_pc   <= skid_pc;
            head_bd   <= skid_bd;
            head_exc  <= skid_exc;
            head_data <= skid_data;
        end else if (drain) begin
            // empty head reads as a nop
            head_ir   <= '0;
            head_bd   <= 1'b0;
            head_exc  <= '0;
            head_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            skid_ir   <= '0;
            skid_pc   <= '0;
            skid_bd   <= 1'b0;
            skid_exc  <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_ir   <= in_ir;
            skid_pc   <= in_pc;
            skid_bd   <= in_bd;
            skid_exc  <= in_exc;
            skid_data <= in_data;
        end
    end

    assign out_ir   = head_ir;
    assign out_pc   = head_pc;
    assign out_bd   = head_bd;
    assign out_data = head_data;

    // overflow resolution on the head instruction
    assign op = head_ir[31:26];
    assign fn = head_ir[5:0];

    assign is_load  = (op == 6'b100011) || (op == 6'b100000) ||
                      (op == 6'b100100) || (op == 6'b100001) ||
                      (op == 6'b100101);
    assign is_store = (op == 6'b101011) || (op == 6'b101000) ||
                      (op == 6'b101001);
    assign is_arith = ((op == 6'b000000) &&
                       (fn == 6'b100000 || fn == 6'b100010)) ||
                      (op == 6'b001000);

    always_comb begin
        out_exc = head_exc;
        if (head_exc == 5'd0 && over && out_valid) begin
            if (is_load)       out_exc = 5'd4;
            else if (is_store) out_exc = 5'd5;
            else if (is_arith) out_exc = 5'd12;
            else               out_exc = 5'd0;
        end
    end

endmodule
